booth4_seq_mult: RTL and testbench
==================================

// Module: booth4_seq_mult
// PURPOSE
//  Iterative radix-4 Booth multiplier; sequential successor to the combinational 8x8 booth4.
//  Width is parametrised and signed/unsigned is selected per operation.
//  It retires one Booth digit (2 multiplier bits) per clock, so area is one adder instead of an array.
//  It connects to the datapath through a start/busy/done handshake.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 4
// PORTS
//  clk    in   1          rising-edge clock
//  rst    in   1          synchronous reset, active-high
//  start  in   1          request; sampled only when not busy
//  tc     in   1          1 = both operands two's complement, 0 = both unsigned
//  a      in   WIDTH      multiplicand
//  b      in   WIDTH      multiplier
//  busy   out  1          operation in progress; start ignored while high
//  done   out  1          one-cycle pulse: prod valid for this operation
//  prod   out  2*WIDTH    product, held until the next accepted start completes
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, busy=0, done=0, prod=0, internal regs cleared.
//   - rst wins over everything, including mid-RUN; a partial result is discarded, no done.
//  Constant N = WIDTH/2+1 iterations, regardless of tc.
//  Operand extension at accept:
//   - a and b are extended to WIDTH+2 bits: sign-extended if tc=1, zero-extended if tc=0.
//   - tc, a and b are latched at accept; later changes to the inputs have no effect.
//  States:
//   - IDLE: busy=0. start=1 at edge k -> latch operands, clear accumulator, iter=0, go RUN.
//   - RUN: busy=1. Each edge performs one iteration:
//     - Decode triplet {b_ext[2i+1], b_ext[2i], b_ext[2i-1]}, with b_ext[-1]=0, into a digit
//       d in {0,+1,+2,-1,-2}: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
//     - Add d*a_ext, done as a (WIDTH+3)-bit two's-complement add into the upper accumulator.
//     - Arithmetic-shift the accumulator:multiplier pair right by 2.
//     - When the Nth iteration completes (edge k+N), write prod = low 2*WIDTH bits of the
//       result and go DONE.
//   - DONE: busy=0, done=1 for exactly one cycle.
//     - Next edge: start=1 -> accept (back-to-back; go RUN). Otherwise go IDLE.
//  Latency: done is high in the cycle after edge k+N (N+1 cycles from accept to done).
//   - WIDTH=8 gives N=5. Throughput is one result per N+1 cycles.
//  prod changes only at the completing edge; it is stable from that edge until the next completion.
//  start while busy=1 is ignored: no queueing, no error flag.
//  The result is exact for all inputs in both modes:
//   - signed -2^(W-1) * -2^(W-1) = 2^(2W-2), which fits;
//   - unsigned (2^W-1)^2 fits.
//  No overflow or saturation logic.
//  A digit of 0 still costs a cycle; no early termination.
// TESTING  (WIDTH=8 unless stated)
//  - tc=1, a=0x1B, b=0x78 -> done after 6 cycles, prod=0x0CA8; tc=1, a=0xAD, b=0x3E -> prod=0xEBE6
//  - Mode: a=b=0xCC with tc=1 -> 0x0A90, tc=0 -> 0xA290; a=b=0xFF with tc=1 -> 0x0001,
//    tc=0 -> 0xFE01
//  - Corners, tc=1: a=0x7F, b=0x80 -> 0xC080; a=b=0x80 -> 0x4000; a=0 with any b -> 0x0000
//  - Handshake: pulse start mid-RUN with new operands -> ignored, prod unchanged; start held
//    high in the DONE cycle -> next result 6 cycles later, done never high 2 cycles in a row
//  - rst asserted at iteration 3 -> next cycle busy=0, done=0, prod=0; a fresh start then
//    gives the correct product
//  - WIDTH=16 random signed and unsigned vectors checked against a behavioural $signed/
//    unsigned multiply model; latency 10 cycles

Source files
------------

// File: rtl/booth4_seq_mult.sv
// booth4_seq_mult: iterative radix-4 Booth multiplier.
// One Booth digit (two multiplier bits) is retired per clock through a single
// adder. Operands are extended to WIDTH+2 bits at accept, sign- or zero-wise
// according to tc. This lets one signed Booth recoding cover both modes exactly.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   st_idle | waiting for start; busy=0
//   st_run  | one Booth iteration per edge; busy=1
//   st_done | done=1 for one cycle; start here is accepted back-to-back
module booth4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int EW = WIDTH + 2;        // extended operand width
    localparam int AW = WIDTH + 3;        // accumulator / adder width
    localparam int N  = WIDTH / 2 + 1;    // Booth iterations per product
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last;

    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   mreg;
    logic            qm1;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [2:0]      trip;
    logic [AW-1:0]   a3;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_nxt;
    logic [EW-1:0]   mreg_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, handshake outputs and per-edge strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            st_idle: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = st_run;
                end
            end
            st_run: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    last      = 1'b1;
                    state_nxt = st_done;
                end
            end
            st_done: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = st_run;
                end else begin
                    state_nxt = st_idle;
                end
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

    // Booth digit selection and one add/shift step of the accumulator pair.
    always_comb begin
        trip = {mreg[1], mreg[0], qm1};
        a3   = {a_ext[EW-1], a_ext};
        case (trip)
            3'b001, 3'b010: addend = a3;
            3'b011:         addend = a3 << 1;
            3'b100:         addend = -(a3 << 1);
            3'b101, 3'b110: addend = -a3;
            default:        addend = '0;
        endcase
        sum      = acc + addend;
        acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mreg_nxt = {sum[1:0], mreg[EW-1:2]};
    end

    // Operand capture at accept, iteration in RUN, result write on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext <= '0;
            mreg  <= '0;
            qm1   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else if (accept) begin
            a_ext <= tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            mreg  <= tc ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
            qm1   <= 1'b0;
            acc   <= '0;
            cnt   <= CW'(N - 1);
        end else if (state == st_run) begin
            acc  <= acc_nxt;
            mreg <= mreg_nxt;
            qm1  <= mreg[1];
            cnt  <= cnt - CW'(1);
            if (last) begin
                // After 2N shifts the low WIDTH+2 product bits sit in mreg.
                prod <= {acc_nxt[WIDTH-3:0], mreg_nxt};
            end
        end
    end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult: WIDTH=8 instance tracked every cycle against a
// transaction-level model, plus a WIDTH=16 instance for random vectors.
module tb_booth4_seq_mult;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, tc8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start16, tc16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] prod16;

    int errors = 0;
    int checks = 0;

    // model state (WIDTH=8)
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_pend = '0;
    int          m_cnt  = 0;
    longint      m_p;

    always #5 clk = ~clk;

    booth4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .tc(tc8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .prod(prod8)
    );

    booth4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .tc(tc16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .prod(prod16)
    );

    function automatic longint ref_mul(input bit tc, input logic [15:0] a,
                                       input logic [15:0] b, input int w);
        longint x;
        longint y;
        x = longint'(a);
        y = longint'(b);
        if (tc && a[w-1]) x = x - (longint'(1) << w);
        if (tc && b[w-1]) y = y - (longint'(1) << w);
        return x * y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: accept when idle, result N=5 edges after accept.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_prod = m_pend;
                end
            end else if (start8) begin
                m_p    = ref_mul(tc8, {8'h00, a8}, {8'h00, b8}, 8);
                m_pend = m_p[15:0];
                m_cnt  = 5;
                m_busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {63'd0, busy8}, {63'd0, m_busy});
        chk("cyc_done", {63'd0, done8}, {63'd0, m_done});
        chk("cyc_prod", {48'd0, prod8}, {48'd0, m_prod});
    end

    task automatic op8(input bit tc, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string name);
        int cyc;
        bit seen;
        start8 = 1'b1; tc8 = tc; a8 = a; b8 = b;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start8 = 1'b0; a8 = ~a; b8 = ~b; tc8 = ~tc;
            end
            if (done8) seen = 1'b1;
        end
        chk({name, "_lat"}, 64'(cyc), 64'd6);
        chk(name, {48'd0, prod8}, {48'd0, exp});
    endtask

    task automatic op16(input bit tc, input logic [15:0] a, input logic [15:0] b);
        int cyc;
        bit seen;
        longint p;
        p = ref_mul(tc, a, b, 16);
        start16 = 1'b1; tc16 = tc; a16 = a; b16 = b;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start16 = 1'b0; a16 = ~a; b16 = ~b;
                chk("w16_busy", {63'd0, busy16}, 64'd1);
            end
            if (done16) seen = 1'b1;
        end
        chk("w16_lat", 64'(cyc), 64'd10);
        chk("w16_prod", {32'd0, prod16}, {32'd0, p[31:0]});
    endtask

    typedef struct {
        bit          tc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b1, 8'h1B, 8'h78, 16'h0CA8},
        '{1'b1, 8'hAD, 8'h3E, 16'hEBE6},
        '{1'b1, 8'hCC, 8'hCC, 16'h0A90},
        '{1'b0, 8'hCC, 8'hCC, 16'hA290},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001},
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
        '{1'b1, 8'h7F, 8'h80, 16'hC080},
        '{1'b1, 8'h80, 8'h80, 16'h4000},
        '{1'b1, 8'h00, 8'h5A, 16'h0000},
        '{1'b1, 8'h00, 8'hFF, 16'h0000}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bit seen;
        longint pin;

        rst = 1'b1;
        start8 = 1'b0; tc8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; tc16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy8}, 64'd0);
        chk("reset_done", {63'd0, done8}, 64'd0);
        chk("reset_prod", {48'd0, prod8}, 64'd0);
        rst = 1'b0;

        pin = ref_mul(1'b1, 16'h00AD, 16'h003E, 8);
        chk("model_pin_s", {48'd0, pin[15:0]}, 64'h0000_0000_0000_EBE6);
        pin = ref_mul(1'b0, 16'h00CC, 16'h00CC, 8);
        chk("model_pin_u", {48'd0, pin[15:0]}, 64'h0000_0000_0000_A290);

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].tc, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("dir%0d", i));
        end

        // start pulsed while RUN must be ignored
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'h1B; b8 = 8'h78;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            start8 = (cyc == 3);
            if (cyc == 3) begin a8 = 8'h55; b8 = 8'h33; end
            if (done8) seen = 1'b1;
        end
        chk("midrun_lat", 64'(cyc), 64'd6);
        chk("midrun_prod", {48'd0, prod8}, 64'h0CA8);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrun_noqueue_done", {63'd0, done8}, 64'd0);
        chk("midrun_noqueue_busy", {63'd0, busy8}, 64'd0);
        chk("midrun_prod_held", {48'd0, prod8}, 64'h0CA8);

        // start held through DONE: back-to-back
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'h1B; b8 = 8'h78;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin a8 = 8'hAD; b8 = 8'h3E; end
            if (done8) seen = 1'b1;
        end
        chk("b2b_first_lat", 64'(cyc), 64'd6);
        chk("b2b_first_prod", {48'd0, prod8}, 64'h0CA8);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start8 = 1'b0;
                chk("b2b_no_double_done", {63'd0, done8}, 64'd0);
                chk("b2b_busy", {63'd0, busy8}, 64'd1);
            end
            if (done8) seen = 1'b1;
        end
        chk("b2b_second_lat", 64'(cyc), 64'd6);
        chk("b2b_second_prod", {48'd0, prod8}, 64'hEBE6);

        // reset in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'h7F; b8 = 8'h80;
        repeat (3) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {63'd0, busy8}, 64'd0);
        chk("rst_mid_done", {63'd0, done8}, 64'd0);
        chk("rst_mid_prod", {48'd0, prod8}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        op8(1'b1, 8'hAD, 8'h3E, 16'hEBE6, "after_rst");

        // WIDTH=16 corners and random vectors
        @(negedge clk);
        op16(1'b1, 16'h8000, 16'h8000);
        chk("w16_corner_s", {32'd0, prod16}, 64'h4000_0000);
        @(negedge clk);
        op16(1'b0, 16'hFFFF, 16'hFFFF);
        chk("w16_corner_u", {32'd0, prod16}, 64'hFFFE_0001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op16(1'(i), 16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
